rf_wb_queue: RTL

- Writeback queue placed between the pipeline's two result producers (ALU and load/memory unit) and the 2-read/1-write register file.
- Merges the two producers into the RF's single write port using valid/ready handshakes and a small in-order FIFO.
- Drives the RF write port (we, dst_addr, dst) from registered outputs, so values are stable at the RF's negedge write.
- Reports read-after-write hazards against pending writes; optionally forwards the pending data instead.

---
 rtl/rf_wb_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_queue.sv
// Writeback queue: merges ALU and load results into the single RF write port
// through an in-order FIFO, and flags RAW hazards against pending writes.
// Optional forwarding of pending data is enabled by defining WB_FWD_EN.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_vld,
    output logic          alu_rdy,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_vld,
    output logic          mem_rdy,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          we,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst,
    input  logic          re0,
    input  logic          re1,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    output logic          hzd0,
    output logic          hzd1,
    output logic          fwd0_vld,
    output logic          fwd1_vld,
    output logic [DW-1:0] fwd0,
    output logic [DW-1:0] fwd1,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry payload carries no reset; only count/pointers define validity.
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] n_push;

    // Load unit gets first claim on the last free slot.
    assign mem_rdy = (count < FULL);
    assign alu_rdy = ((count + CW'(mem_vld)) < FULL);

    // Register 0 is hardwired to zero, so those writes complete but vanish.
    assign mem_push = mem_vld && mem_rdy && (mem_addr != '0);
    assign alu_push = alu_vld && alu_rdy && (alu_addr != '0);
    assign pop      = (count != '0);
    assign alu_slot = mem_push ? (wr_ptr + PW'(1)) : wr_ptr;
    assign n_push   = CW'(mem_push) + CW'(alu_push);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[wr_ptr] <= mem_addr;
            data_q[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_addr;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
        end else begin
            count  <= count + n_push - CW'(pop);
            wr_ptr <= wr_ptr + PW'(n_push);
            we     <= pop;
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                dst_addr <= addr_q[rd_ptr];
                dst      <= data_q[rd_ptr];
            end
        end
    end

    assign empty = (count == '0) && !we;

    logic          port_act  [2];
    logic [AW-1:0] port_addr [2];
    logic          match     [2];
    logic [PW-1:0] idx;

    assign port_act[0]  = re0 && (p0_addr != '0);
    assign port_act[1]  = re1 && (p1_addr != '0);
    assign port_addr[0] = p0_addr;
    assign port_addr[1] = p1_addr;

`ifdef WB_FWD_EN
    logic [DW-1:0] fdata [2];
`endif

    // Scan oldest to youngest so the last hit is the newest pending write;
    // the output stage is older than every FIFO entry.
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            match[p] = port_act[p] && we && (dst_addr == port_addr[p]);
`ifdef WB_FWD_EN
            fdata[p] = dst;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (port_act[p] && (CW'(i) < count) && (addr_q[idx] == port_addr[p])) begin
                    match[p] = 1'b1;
`ifdef WB_FWD_EN
                    fdata[p] = data_q[idx];
`endif
                end
            end
        end
    end

`ifdef WB_FWD_EN
    assign hzd0     = 1'b0;
    assign hzd1     = 1'b0;
    assign fwd0_vld = match[0];
    assign fwd1_vld = match[1];
    assign fwd0     = match[0] ? fdata[0] : '0;
    assign fwd1     = match[1] ? fdata[1] : '0;
`else
    assign hzd0     = match[0];
    assign hzd1     = match[1];
    assign fwd0_vld = 1'b0;
    assign fwd1_vld = 1'b0;
    assign fwd0     = '0;
    assign fwd1     = '0;
`endif

endmodule
